// File: rtl/versatile_io_wbm.sv
// ============================================================================
// Module   : versatile_io_wbm
// Purpose  : Single-outstanding Wishbone B3 classic master with a
//            valid/ready command and response interface and a bus timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module versatile_io_wbm #(
    parameter int TIMEOUT = 255
) (
    input  logic        wbm_clk,
    input  logic        wbm_rst,

    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,

    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_stb_o,
    output logic        wbm_cyc_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i
);

    // Counter value seen on the last permitted bus cycle.
    localparam logic [7:0] C_TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RSP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rsp_dat_q, rsp_dat_d;
    logic        rsp_err_q, rsp_err_d;

    always_ff @(posedge wbm_clk) begin
        if (wbm_rst) begin
            state_q   <= S_IDLE;
            adr_q     <= 32'h0;
            dat_q     <= 32'h0;
            sel_q     <= 4'h0;
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            cnt_q     <= 8'h0;
            rsp_dat_q <= 32'h0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            adr_q     <= adr_d;
            dat_q     <= dat_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            cnt_q     <= cnt_d;
            rsp_dat_q <= rsp_dat_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        adr_d     = adr_q;
        dat_d     = dat_q;
        sel_d     = sel_q;
        we_d      = we_q;
        cyc_d     = cyc_q;
        cnt_d     = cnt_q;
        rsp_dat_d = rsp_dat_q;
        rsp_err_d = rsp_err_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    adr_d   = cmd_adr;
                    dat_d   = cmd_dat;
                    sel_d   = cmd_sel;
                    we_d    = cmd_we;
                    cyc_d   = 1'b1;
                    cnt_d   = 8'h0;
                    state_d = S_BUS;
                end
            end
            S_BUS: begin
                // err wins over ack; a silent slave on the last cycle is an error too.
                if (wbm_err_i || (!wbm_ack_i && (cnt_q == C_TO_LAST))) begin
                    cyc_d     = 1'b0;
                    rsp_err_d = 1'b1;
                    rsp_dat_d = 32'h0;
                    state_d   = S_RSP;
                end else if (wbm_ack_i) begin
                    cyc_d     = 1'b0;
                    rsp_err_d = 1'b0;
                    rsp_dat_d = we_q ? 32'h0 : wbm_dat_i;
                    state_d   = S_RSP;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = (state_q == S_RSP);
    assign rsp_dat   = rsp_dat_q;
    assign rsp_err   = rsp_err_q;

    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign wbm_sel_o = sel_q;
    assign wbm_we_o  = we_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;

endmodule

`default_nettype wire

// File: tb/tb_versatile_io_wbm.sv
// ============================================================================
// Module   : tb_versatile_io_wbm
// Purpose  : Randomized self-checking bench for versatile_io_wbm against a
//            transaction-level reference of the expected bus/response outcome.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_versatile_io_wbm;

    localparam int C_TO = 4;

    // Slave behaviour kinds.
    localparam int C_ACK    = 0;
    localparam int C_ERR    = 1;
    localparam int C_BOTH   = 2;
    localparam int C_SILENT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_we;
    logic [31:0] cmd_adr;
    logic [31:0] cmd_dat;
    logic [3:0]  cmd_sel;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_dat;
    logic        rsp_err;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_stb_o;
    logic        wbm_cyc_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;
    logic        wbm_err_i;

    int n_chk  = 0;
    int n_fail = 0;

    versatile_io_wbm #(.TIMEOUT(C_TO)) u_dut (
        .wbm_clk   (clk),
        .wbm_rst   (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_adr   (cmd_adr),
        .cmd_dat   (cmd_dat),
        .cmd_sel   (cmd_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_dat   (rsp_dat),
        .rsp_err   (rsp_err),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i),
        .wbm_err_i (wbm_err_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One full transaction: the reference outcome is derived from the slave
    // behaviour chosen (kind, wait states) and the timeout limit.
    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input int kind, input int waits,
                          input int hold);
        int          k;
        logic [31:0] rd;
        logic        respond;
        int          exp_len;
        logic        exp_err;
        logic [31:0] exp_dat;
        logic [31:0] held_dat;
        logic        held_err;

        rd = 32'h0;
        chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_adr   = adr;
        cmd_dat   = dat;
        cmd_sel   = sel;
        cycle();
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_adr   = $urandom();
        cmd_dat   = $urandom();
        cmd_sel   = 4'($urandom());
        cmd_we    = ~we;

        k = 0;
        while (wbm_cyc_o && k < C_TO + 3) begin
            if (wbm_adr_o !== adr || wbm_dat_o !== dat || wbm_sel_o !== sel ||
                wbm_we_o !== we || wbm_stb_o !== 1'b1 || cmd_ready !== 1'b0 ||
                rsp_valid !== 1'b0) begin
                chk("bus_hold", {wbm_adr_o[15:0], 4'h0, wbm_sel_o, 5'h0, wbm_we_o, wbm_stb_o, rsp_valid},
                                {adr[15:0], 4'h0, sel, 5'h0, we, 1'b1, 1'b0});
            end
            wbm_dat_i = $urandom();
            wbm_ack_i = (k == waits) && (kind == C_ACK || kind == C_BOTH);
            wbm_err_i = (k == waits) && (kind == C_ERR || kind == C_BOTH);
            if (k == waits) rd = wbm_dat_i;
            cycle();
            k++;
        end
        cmd_valid = 1'b0;

        respond = (kind != C_SILENT) && (waits < C_TO);
        exp_len = respond ? waits + 1 : C_TO;
        exp_err = !respond || (kind != C_ACK);
        exp_dat = (respond && kind == C_ACK && !we) ? rd : 32'h0;

        chk("cyc_len", 32'(k), 32'(exp_len));
        chk("cyc_eq_stb", 32'(wbm_stb_o), 32'(wbm_cyc_o));
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_dat", rsp_dat, exp_dat);
        chk("rsp_err", 32'(rsp_err), 32'(exp_err));
        held_dat = rsp_dat;
        held_err = rsp_err;

        rsp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            wbm_ack_i = 1'($urandom());
            wbm_err_i = 1'($urandom());
            wbm_dat_i = $urandom();
            cycle();
            if (rsp_valid !== 1'b1 || rsp_dat !== held_dat || rsp_err !== held_err ||
                cmd_ready !== 1'b0 || wbm_cyc_o !== 1'b0) begin
                chk("rsp_hold", {rsp_dat[27:0], rsp_valid, rsp_err, cmd_ready, wbm_cyc_o},
                                {held_dat[27:0], 1'b1, held_err, 1'b0, 1'b0});
            end
        end
        rsp_ready = 1'b1;
        cycle();
        rsp_ready = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        chk("rsp_done_valid", 32'(rsp_valid), 32'd0);
        chk("rsp_done_ready", 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h0;
        cmd_dat   = 32'h0;
        cmd_sel   = 4'h0;
        rsp_ready = 1'b0;
        wbm_dat_i = 32'h0;
        wbm_ack_i = 1'b0;
        wbm_err_i = 1'b0;
        @(negedge clk);
        cycle();
        chk("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("rst_stb", 32'(wbm_stb_o), 32'd0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        chk("rst_dat", wbm_dat_o, 32'h0);
        chk("rst_sel", 32'(wbm_sel_o), 32'h0);
        chk("rst_we", 32'(wbm_we_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_dat", rsp_dat, 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        rst = 1'b0;
        cycle();

        // Zero-wait read, 3-wait write, ack+err, silent slave, back-pressure.
        do_txn(1'b0, 32'h9000_0004, 32'h0, 4'hF, C_ACK, 0, 0);
        do_txn(1'b1, 32'h9000_0000, 32'h0000_0041, 4'h1, C_ACK, 3, 0);
        do_txn(1'b0, 32'h9000_0008, 32'h0, 4'hF, C_BOTH, 1, 1);
        do_txn(1'b0, 32'h9000_000C, 32'h0, 4'hF, C_SILENT, 0, 0);
        do_txn(1'b0, 32'h9000_0010, 32'h0, 4'hF, C_ACK, C_TO - 1, 10);
        do_txn(1'b1, 32'h9000_0014, 32'h1234_5678, 4'h3, C_ACK, C_TO, 0);

        for (int t = 0; t < 60; t++) begin
            do_txn(1'($urandom()), $urandom(), $urandom(), 4'($urandom()),
                   int'($urandom_range(0, 3)), int'($urandom_range(0, C_TO + 1)),
                   int'($urandom_range(0, 3)));
        end

        // Reset on the second bus cycle aborts with no response.
        cmd_valid = 1'b1;
        cmd_we    = 1'b0;
        cmd_adr   = 32'h9000_0020;
        cmd_sel   = 4'hF;
        cycle();
        cmd_valid = 1'b0;
        chk("abort_bus1", 32'(wbm_cyc_o), 32'd1);
        cycle();
        chk("abort_bus2", 32'(wbm_cyc_o), 32'd1);
        rst = 1'b1;
        cycle();
        chk("abort_cyc", 32'(wbm_cyc_o), 32'd0);
        chk("abort_stb", 32'(wbm_stb_o), 32'd0);
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        rst = 1'b0;
        cycle();
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
        do_txn(1'b0, 32'h9000_0024, 32'h0, 4'hF, C_ACK, 2, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
